// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, widths, FSM states.
package alu_muldiv_pkg;

    localparam int unsigned DATA_WIDTH_GPR   = 32;
    localparam int unsigned DATA_WIDTH_MD_OP = 3;

    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_MUL    = 3'd0;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_MULH   = 3'd1;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_MULHSU = 3'd2;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_MULHU  = 3'd3;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_DIV    = 3'd4;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_DIVU   = 3'd5;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_REM    = 3'd6;
    localparam logic [DATA_WIDTH_MD_OP-1:0] MD_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the engine: shift-add multiply (mode 0) or restoring divide (mode 1).
module alu_muldiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            div_mode,
    input  logic            sub_pp,
    input  logic [XLEN:0]   hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN:0]   opnd,
    output logic [XLEN:0]   hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN+1:0] mul_addend;
    logic [XLEN+1:0] mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    // Multiply: partial product on lo[0], arithmetic shift of {hi, lo} right by one.
    always_comb begin
        mul_addend = '0;
        if (lo[0]) begin
            mul_addend = sub_pp ? -{opnd[XLEN], opnd} : {opnd[XLEN], opnd};
        end
        mul_sum = {hi[XLEN], hi} + mul_addend;
    end

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        div_shift = {hi[XLEN-1:0], lo[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {1'b0, opnd};
    end

    always_comb begin
        hi_nxt = mul_sum[XLEN+1:1];
        lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        if (div_mode) begin
            if (!div_diff[XLEN+1]) begin
                hi_nxt = div_diff[XLEN:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift;
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, with RISC-V divide special-case fast path.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = DATA_WIDTH_GPR,
    parameter int unsigned TAG_W = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH_MD_OP-1:0] in_op,
    input  logic [XLEN-1:0]             in_a,
    input  logic [XLEN-1:0]             in_b,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_data,
    output logic [TAG_W-1:0]            out_tag,
    output logic                        busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e                 state;
    logic [CNT_W-1:0]          cnt_q;
    logic [DATA_WIDTH_MD_OP-1:0] op_q;
    logic [TAG_W-1:0]          tag_q;
    logic [XLEN:0]             hi_q;
    logic [XLEN-1:0]           lo_q;
    logic [XLEN:0]             opnd_q;
    logic                      sub_q;
    logic                      neg_q_q;
    logic                      neg_r_q;

    logic [XLEN:0]   hi_nxt;
    logic [XLEN-1:0] lo_nxt;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            is_special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] calc_res;

    // Operand signedness and magnitudes for the incoming request.
    always_comb begin
        a_signed = (in_op == MD_OP_MULH) || (in_op == MD_OP_MULHSU) ||
                   (in_op == MD_OP_DIV)  || (in_op == MD_OP_REM);
        b_signed = (in_op == MD_OP_MULH) || (in_op == MD_OP_DIV) || (in_op == MD_OP_REM);
        a_neg    = a_signed && in_a[XLEN-1];
        b_neg    = b_signed && in_b[XLEN-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
    end

    // Divide-by-zero and signed-overflow bypass the iterative engine.
    always_comb begin
        is_special  = 1'b0;
        special_res = '0;
        if (in_op[2]) begin
            if (in_b == '0) begin
                is_special  = 1'b1;
                special_res = in_op[1] ? in_a : '1;
            end else if (!in_op[0] && (in_a == MIN_INT) && (in_b == '1)) begin
                is_special  = 1'b1;
                special_res = in_op[1] ? '0 : MIN_INT;
            end
        end
    end

    alu_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .div_mode (op_q[2]),
        .sub_pp   (sub_q && (cnt_q == '0)),
        .hi       (hi_q),
        .lo       (lo_q),
        .opnd     (opnd_q),
        .hi_nxt   (hi_nxt),
        .lo_nxt   (lo_nxt)
    );

    // Result selection and sign post-correction after the final iteration.
    always_comb begin
        calc_res = hi_nxt[XLEN-1:0];
        case (op_q)
            MD_OP_MUL:  calc_res = lo_nxt;
            MD_OP_DIV:  calc_res = neg_q_q ? -lo_nxt : lo_nxt;
            MD_OP_DIVU: calc_res = lo_nxt;
            MD_OP_REM:  calc_res = neg_r_q ? -hi_nxt[XLEN-1:0] : hi_nxt[XLEN-1:0];
            MD_OP_REMU: calc_res = hi_nxt[XLEN-1:0];
            default:    calc_res = hi_nxt[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MD_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            busy      <= 1'b0;
            cnt_q     <= '0;
            op_q      <= MD_OP_MUL;
            tag_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            sub_q     <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else if (flush) begin
            state     <= MD_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= in_op;
                        tag_q    <= in_tag;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (is_special) begin
                            state     <= MD_DONE;
                            out_valid <= 1'b1;
                            out_data  <= special_res;
                            out_tag   <= in_tag;
                        end else begin
                            state   <= MD_CALC;
                            cnt_q   <= CNT_W'(XLEN - 1);
                            hi_q    <= '0;
                            sub_q   <= b_signed && !in_op[2];
                            neg_q_q <= a_neg ^ b_neg;
                            neg_r_q <= a_neg;
                            if (in_op[2]) begin
                                lo_q   <= a_mag;
                                opnd_q <= {1'b0, b_mag};
                            end else begin
                                lo_q   <= in_b;
                                opnd_q <= {a_signed && in_a[XLEN-1], in_a};
                            end
                        end
                    end
                end
                MD_CALC: begin
                    hi_q <= hi_nxt;
                    lo_q <= lo_nxt;
                    if (cnt_q == '0) begin
                        state     <= MD_DONE;
                        out_valid <= 1'b1;
                        out_data  <= calc_res;
                        out_tag   <= tag_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    if (out_ready) begin
                        state     <= MD_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= MD_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] MIN = 32'h8000_0000;

    alu_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result from RISC-V M-extension semantics using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin r = sa * sb; p = r; return p[63:32]; end
            3'd2: begin r = sa * ub; p = r; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                r = sa / sb; p = r; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb; p = r; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, measure latency, hold the result for 'hold' cycles, then take it.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tg, input int hold);
        int          lat;
        logic [31:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        check({name, ".in_ready"}, 64'(in_ready), 64'(1));
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tg;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".latency"}, 64'(lat), 64'(model_lat(op, a, b)));
        check({name, ".data"}, 64'(out_data), 64'(exp));
        check({name, ".tag"}, 64'(out_tag), 64'(tg));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({name, ".hold_data"}, 64'(out_data), 64'(exp));
            check({name, ".hold_valid"}, 64'(out_valid), 64'(1));
            check({name, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, ".post_valid"}, 64'(out_valid), 64'(0));
        check({name, ".post_in_ready"}, 64'(in_ready), 64'(1));
        check({name, ".post_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".in_ready"}, 64'(in_ready), 64'(1));
        check({name, ".out_valid"}, 64'(out_valid), 64'(0));
        check({name, ".out_data"}, 64'(out_data), 64'(0));
        check({name, ".out_tag"}, 64'(out_tag), 64'(0));
        check({name, ".busy"}, 64'(busy), 64'(0));
    endtask

    logic [31:0] edge_vals [6];

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        edge_vals[0] = 32'h0;
        edge_vals[1] = 32'h1;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = MIN;
        edge_vals[4] = 32'h7FFF_FFFF;
        edge_vals[5] = 32'h2;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op("mul_7_m3",   3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        run_op("mulh",       3'd1, MIN, 32'hFFFF_FFFF, 5'd4, 0);
        run_op("mulhsu",     3'd2, MIN, 32'hFFFF_FFFF, 5'd5, 0);
        run_op("mulhu",      3'd3, MIN, 32'hFFFF_FFFF, 5'd6, 0);
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd9, 0);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 0);
        run_op("div_by0",    3'd4, 32'd5, 32'd0, 5'd11, 0);
        run_op("remu_by0",   3'd7, 32'd5, 32'd0, 5'd12, 0);
        run_op("div_ovf",    3'd4, MIN, 32'hFFFF_FFFF, 5'd13, 0);
        run_op("rem_ovf",    3'd6, MIN, 32'hFFFF_FFFF, 5'd14, 0);
        run_op("backpress",  3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 10);

        // Flush in the tenth CALC cycle, then a fresh op right after.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd123;
        in_b     = 32'd456;
        in_tag   = 5'd16;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.out_valid", 64'(out_valid), 64'(0));
        check("flush.in_ready", 64'(in_ready), 64'(1));
        check("flush.busy", 64'(busy), 64'(0));
        run_op("after_flush", 3'd5, 32'd1000, 32'd9, 5'd17, 0);

        // Synchronous reset in the middle of CALC.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 3'd4;
        in_a     = 32'd77;
        in_b     = 32'd5;
        in_tag   = 5'd18;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        // Randomized ops with a bias toward boundary operands.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            run_op("rand", op, a, b, 5'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multiply/divide unit for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the combinational integer ALU in the execute stage.
- Iterative engine: one bit per cycle, with a valid/ready handshake on both sides. The pipeline stalls while the unit is busy.
- Fast-paths the RISC-V special cases: divide-by-zero and signed overflow.

Parameters:
- XLEN, 32: operand and result width. Must be even and >= 8.
- TAG_W, 5: width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  cancels any accepted or in-flight operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- in_op  in  3  operation select: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7 (equals RISC-V funct3).
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  destination register tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_tag=0, busy=0, counter=0. Reset overrides every other input.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - On in_valid && in_ready, latch op, tag and operands.
  - Special case (next state DONE, 1-cycle latency, out_valid in the following cycle):
    - divide op with b==0: DIV/DIVU give all-ones; REM/REMU give a.
    - DIV with a==MIN_INT && b==-1: result MIN_INT.
    - REM with a==MIN_INT && b==-1: result 0.
  - Otherwise: next state CALC, counter=XLEN-1.
- CALC: one iteration per cycle.
  - Leaves to DONE after the iteration where counter==0, i.e. exactly XLEN CALC cycles.
  - Total latency from the accept edge to out_valid=1 is XLEN+1 cycles (33 for XLEN=32).
- Multiply:
  - Operands are sign-extended per op to XLEN+1 bits: MULH both signed, MULHSU a signed and b unsigned, MUL/MULHU unsigned.
  - Shift-add into a 2*XLEN accumulator; a signed multiplier's final partial product is subtracted.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes; DIV/REM take the absolute value of signed operands.
  - Quotient is negated when the operand signs differ (DIV). Remainder takes the sign of the dividend (REM).
  - Unsigned ops are used as-is.
- DONE:
  - out_valid=1; out_data and out_tag held stable.
  - On out_ready, go to IDLE; in_ready rises on the next cycle. No back-to-back accept in the same cycle as out handshake.
  - If out_ready stays low, the result is held indefinitely.
- Flush:
  - flush=1 in any state: next state IDLE, out_valid=0; the result is discarded.
  - flush has priority over in_valid, so no accept happens that cycle.
- Result datapath registers update only on FSM transitions; outputs are always registered, with no combinational path from in_* to out_*.
- The shift amount or counter never wraps. Counter width is clog2(XLEN).

Decomposition:
- Shared define package holds:
  - MD_OP_* codes (3-bit).
  - DATA_WIDTH_MD_OP.
  - The default XLEN, aliased to DATA_WIDTH_GPR.
- One natural sub-module: alu_muldiv_step, the combinational single-iteration add/sub-shift step (mul or div mode) instantiated inside the FSM.
- Sign pre- and post-correction stays in the top level.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> out_data 0xFFFFFFEB, out_valid exactly 33 cycles after accept, out_tag echoed.
- MULH / MULHSU / MULHU with a=0x80000000, b=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- DIV/REM a=-7, b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14, REMU -> 2.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000.
  - REM a=0x80000000, b=-1 -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data stable and in_ready=0; raise out_ready -> IDLE with in_ready=1 one cycle later.
- Flush and reset:
  - Assert flush in CALC cycle 10 -> out_valid never rises; a new op is accepted the next cycle and returns the correct result.
  - Assert rst mid-CALC -> all outputs return to reset values on the next edge.
